esm_slot_scheduler: RTL and testbench

- Arbitrates buffer slots among NREQ requesters in the ESM buffer subsystem.
- Grants each winning requester one eligible slot, chosen uniformly at random by an internal LFSR.
- Eligible slot = set in external cand_list and not currently busy.
- Tracks busy slots until the requester releases them; the granted index drives the buffer write address.

---
 rtl/esm_pkg.sv | 18 +
 rtl/kth_set_bit.sv | 30 +++
 rtl/esm_slot_scheduler.sv | 130 +++++++++++++
 tb/tb_esm_slot_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared constants, LFSR step and FSM states for the ESM slot scheduler
package esm_pkg;
    localparam int          BS_DEF        = 16;
    localparam int          BS_BITS       = $clog2(BS_DEF);
    // Galois right-shift taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        GRANT
    } sched_state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
endpackage

// File: rtl/kth_set_bit.sv
// rtl/kth_set_bit.sv - index of the k-th set bit (0-based, LSB first) of a vector
module kth_set_bit
    import esm_pkg::*;
#(
    parameter int BS = BS_DEF
) (
    input  logic [BS-1:0]         i_vec,
    input  logic [$clog2(BS):0]   i_k,
    output logic [$clog2(BS)-1:0] o_idx,
    output logic                  o_found
);
    localparam int IW = $clog2(BS);

    logic [IW:0] w_seen;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_seen  = '0;
        for (int i = 0; i < BS; i++) begin
            if (i_vec[i]) begin
                if (!o_found && w_seen == i_k) begin
                    o_idx   = IW'(i);
                    o_found = 1'b1;
                end
                w_seen = w_seen + 1'b1;
            end
        end
    end
endmodule

// File: rtl/esm_slot_scheduler.sv
// rtl/esm_slot_scheduler.sv - round-robin requester arbitration with random free-slot pick; ESM_SCHED_DETERMINISTIC_EN forces lowest slot
module esm_slot_scheduler
    import esm_pkg::*;
#(
    parameter int          BS        = BS_DEF,
    parameter int          NREQ      = 4,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BS-1:0]         cand_list,
    input  logic [NREQ-1:0]       req,
    input  logic                  rel_valid,
    input  logic [$clog2(BS)-1:0] rel_idx,
    output logic [NREQ-1:0]       gnt,
    output logic [$clog2(BS)-1:0] gnt_idx,
    output logic [BS-1:0]         busy_map,
    output logic                  full
);
    localparam int IW = $clog2(BS);
    localparam int KW = IW + 1;
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t    r_state;
    logic [15:0]     r_lfsr;
    logic [RW-1:0]   r_ptr;
    logic [RW-1:0]   r_win;
    logic [BS-1:0]   r_snap;
    logic [KW-1:0]   r_k;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_gnt_idx;
    logic [BS-1:0]   r_busy;
    logic            r_full;

    logic [BS-1:0]   w_elig;
    logic [KW-1:0]   w_cnt;
    logic [KW-1:0]   w_k;
    logic [RW-1:0]   w_win;
    logic [RW-1:0]   w_j;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    logic [BS-1:0]   w_one_bs;
    logic [BS-1:0]   w_rel_mask;
    logic [BS-1:0]   w_set_mask;
    logic [BS-1:0]   w_busy_next;

    assign w_elig   = cand_list & ~r_busy;
    assign w_cnt    = KW'($countones(w_elig));
    assign w_one_bs = {{(BS-1){1'b0}}, 1'b1};

`ifdef ESM_SCHED_DETERMINISTIC_EN
    assign w_k = '0;
`else
    // full-width count as divisor so cnt==BS stays valid; k < cnt by construction
    assign w_k = (w_cnt == '0) ? '0 : KW'(32'(r_lfsr) % 32'(w_cnt));
`endif

    always_comb begin
        w_win = r_ptr;
        w_j   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_j = RW'((32'(r_ptr) + i) % NREQ);
            if (req[w_j]) begin
                w_win = w_j;
            end
        end
    end

    kth_set_bit #(.BS(BS)) u_kth (
        .i_vec   (r_snap),
        .i_k     (r_k),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    // a set in SELECT overrides a release of the same slot
    assign w_rel_mask  = rel_valid ? (w_one_bs << rel_idx) : '0;
    assign w_set_mask  = (r_state == SELECT && w_found) ? (w_one_bs << w_idx) : '0;
    assign w_busy_next = (r_busy & ~w_rel_mask) | w_set_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_lfsr    <= LFSR_SEED;
            r_ptr     <= '0;
            r_win     <= '0;
            r_snap    <= '0;
            r_k       <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_busy    <= '0;
            r_full    <= 1'b0;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
            r_busy <= w_busy_next;
            case (r_state)
                IDLE: begin
                    r_gnt  <= '0;
                    r_full <= (|req) && (w_cnt == '0);
                    if ((|req) && (w_cnt != '0)) begin
                        r_snap  <= w_elig;
                        r_k     <= w_k;
                        r_win   <= w_win;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    r_full    <= 1'b0;
                    r_gnt_idx <= w_idx;
                    r_gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << r_win;
                    r_state   <= GRANT;
                end
                GRANT: begin
                    r_gnt   <= '0;
                    r_ptr   <= (r_win == RW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign gnt_idx  = r_gnt_idx;
    assign busy_map = r_busy;
    assign full     = r_full;
endmodule

// File: tb/tb_esm_slot_scheduler.sv
// tb/tb_esm_slot_scheduler.sv - self-checking bench for esm_slot_scheduler
`timescale 1ns/1ps
module tb_esm_slot_scheduler;
    localparam int BS   = 16;
    localparam int NREQ = 4;
`ifdef ESM_SCHED_DETERMINISTIC_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cand_list;
    logic [3:0]  req;
    logic        rel_valid;
    logic [3:0]  rel_idx;
    logic [3:0]  gnt;
    logic [3:0]  gnt_idx;
    logic [15:0] busy_map;
    logic        full;

    always #5 clk = ~clk;

    esm_slot_scheduler #(.BS(BS), .NREQ(NREQ), .LFSR_SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cand_list (cand_list),
        .req       (req),
        .rel_valid (rel_valid),
        .rel_idx   (rel_idx),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .busy_map  (busy_map),
        .full      (full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // reference model state
    logic [15:0] m_lfsr;
    logic [15:0] m_busy;
    int          m_ptr;
    bit          m_inrst = 1'b1;
    logic [15:0] c1_lfsr, c2_lfsr, c1_elig, c2_elig, c1_rel;
    logic [3:0]  c1_req, c2_req, prev_gnt;
    int          slot_cnt[16];
    bit          count_en = 1'b0;

    function automatic logic [15:0] model_lfsr_next(input logic [15:0] s);
        int          taps[4] = '{16, 14, 13, 11};
        logic [15:0] mask = '0;
        foreach (taps[t]) mask[taps[t]-1] = 1'b1;
        if (s[0]) return (s >> 1) ^ mask;
        return s >> 1;
    endfunction

    function automatic int model_kth(input logic [15:0] v, input int k);
        int seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                if (seen == k) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int model_rr(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // c1 = inputs seen at the edge just taken, c2 = the edge before (snapshot edge of a grant)
    task automatic monitor();
        logic [15:0] nb;
        int          c, k, ei, ew;
        if (!rst) begin
            m_lfsr   = 16'hACE1;
            m_busy   = '0;
            m_ptr    = 0;
            m_inrst  = 1'b1;
            prev_gnt = '0;
            c1_lfsr = '0; c2_lfsr = '0; c1_elig = '0; c2_elig = '0; c1_rel = '0;
            c1_req = '0; c2_req = '0;
            chk("rst_gnt", gnt, 0);
            chk("rst_busy", busy_map, 0);
        end else begin
            if (!m_inrst) begin
                m_lfsr = model_lfsr_next(m_lfsr);
                nb = m_busy & ~c1_rel;
                if (gnt != '0) begin
                    c  = $countones(c2_elig);
                    k  = (DET || c == 0) ? 0 : int'(c2_lfsr) % c;
                    ei = model_kth(c2_elig, k);
                    ew = model_rr(c2_req, m_ptr);
                    chk("mon_gnt", gnt, (ew < 0) ? 0 : (1 << ew));
                    chk("mon_gnt_idx", gnt_idx, ei);
                    chk("mon_gnt_elig", c2_elig[gnt_idx], 1);
                    chk("mon_gnt_pulse", prev_gnt, 0);
                    if (ei >= 0) nb[ei] = 1'b1;
                    if (ew >= 0) m_ptr = (ew + 1) % NREQ;
                    if (count_en) slot_cnt[gnt_idx]++;
                end
                m_busy = nb;
                chk("mon_busy_map", busy_map, m_busy);
            end
            prev_gnt = gnt;
            c2_lfsr = c1_lfsr; c2_elig = c1_elig; c2_req = c1_req;
            c1_lfsr = m_lfsr;
            c1_elig = cand_list & ~m_busy;
            c1_req  = req;
            c1_rel  = rel_valid ? (16'h1 << rel_idx) : 16'h0;
            m_inrst = 1'b0;
        end
    endtask

    // every input change happens 1ns after a rising edge; outputs are read there too
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic grant_one(input logic [3:0] r, input string name);
        int n = 0;
        req = r;
        while (gnt == '0 && n < 12) begin
            step();
            n++;
        end
        chk(name, (gnt != '0), 1);
        req = '0;
        step();
    endtask

    typedef struct packed {
        logic [15:0] cand;
        logic [3:0]  rq;
        logic        rel_v;
        logic [3:0]  rel_i;
        logic [3:0]  e_gnt;
        logic [3:0]  e_idx;
        logic [15:0] e_busy;
    } vec_t;

    vec_t tbl[10];
    int   held[$];
    int   gcnt, cyc;

    initial begin
        tbl[0] = '{16'h0010, 4'b0001, 1'b0, 4'd0, 4'b0001, 4'd4,  16'h0010};
        tbl[1] = '{16'h0001, 4'b1111, 1'b0, 4'd0, 4'b0010, 4'd0,  16'h0011};
        tbl[2] = '{16'h0002, 4'b1111, 1'b0, 4'd0, 4'b0100, 4'd1,  16'h0013};
        tbl[3] = '{16'h0004, 4'b1111, 1'b0, 4'd0, 4'b1000, 4'd2,  16'h0017};
        tbl[4] = '{16'h0008, 4'b1111, 1'b0, 4'd0, 4'b0001, 4'd3,  16'h001F};
        tbl[5] = '{16'h0020, 4'b0001, 1'b1, 4'd3, 4'b0001, 4'd5,  16'h0037};
        tbl[6] = '{16'h0100, 4'b0010, 1'b1, 4'd7, 4'b0010, 4'd8,  16'h0137};
        tbl[7] = '{16'h0070, 4'b1000, 1'b1, 4'd4, 4'b1000, 4'd6,  16'h0167};
        tbl[8] = '{16'h0200, 4'b0100, 1'b1, 4'd9, 4'b0100, 4'd9,  16'h0367};
        tbl[9] = '{16'h0400, 4'b0101, 1'b0, 4'd0, 4'b0001, 4'd10, 16'h0767};

        rst = 1'b0; cand_list = '0; req = '0; rel_valid = 1'b0; rel_idx = '0;
        step();
        step();
        chk("reset_gnt", gnt, 0);
        chk("reset_gnt_idx", gnt_idx, 0);
        chk("reset_busy", busy_map, 0);
        chk("reset_full", full, 0);
        rst = 1'b1;

        // three cycles per grant: drive, SELECT, GRANT
        for (int i = 0; i < 10; i++) begin
            cand_list = tbl[i].cand;
            req       = tbl[i].rq;
            step();
            chk($sformatf("vec%0d_gnt_early", i), gnt, 0);
            rel_valid = tbl[i].rel_v;
            rel_idx   = tbl[i].rel_i;
            step();
            chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].e_gnt);
            chk($sformatf("vec%0d_gnt_idx", i), gnt_idx, tbl[i].e_idx);
            chk($sformatf("vec%0d_busy", i), busy_map, tbl[i].e_busy);
            rel_valid = 1'b0;
            req       = '0;
            step();
            chk($sformatf("vec%0d_gnt_off", i), gnt, 0);
        end

        // exhaustion: both candidates taken, then a release frees slot 1
        do_reset();
        cand_list = 16'h0003;
        grant_one(4'b0001, "full_pre_grant0");
        grant_one(4'b0001, "full_pre_grant1");
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_gnt", gnt, 0);
        end
        chk("full_set", full, 1);
        rel_valid = 1'b1;
        rel_idx   = 4'd1;
        step();
        rel_valid = 1'b0;
        step();
        chk("full_clear", full, 0);
        grant_one(4'b0001, "full_regrant");
        chk("full_regrant_idx", gnt_idx, 1);

        // reset pulled in SELECT aborts the grant
        do_reset();
        cand_list = 16'h0100;
        grant_one(4'b0010, "midrst_pre_grant");
        cand_list = 16'h00F0;
        req = 4'b0001;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy_map, 0);
        chk("midrst_gnt", gnt, 0);
        step();
        step();
        chk("midrst_gnt_hold", gnt, 0);
        req = 4'b1111;
        rst = 1'b1;
        step();
        chk("postrst_gnt_early", gnt, 0);
        step();
        chk("postrst_gnt", gnt, 4'b0001);
        chk("postrst_idx_range", (gnt_idx >= 4'd4 && gnt_idx <= 4'd7), 1);
        req = '0;
        step();

        // randomized grant/release traffic checked by the monitor
        do_reset();
        cand_list = 16'hFFFF;
        count_en = 1'b1;
        gcnt = 0;
        cyc  = 0;
        while (gcnt < 1000 && cyc < 20000) begin
            rel_valid = 1'b0;
            if (gnt != '0) begin
                req = req & ~gnt;
                held.push_back(int'(gnt_idx));
                gcnt++;
            end
            if ($urandom_range(0, 1) == 1) req = req | 4'($urandom);
            if (held.size() > 0 && held.size() > int'($urandom_range(0, 5))) begin
                rel_valid = 1'b1;
                rel_idx   = 4'(held.pop_front());
            end
            step();
            cyc++;
        end
        count_en  = 1'b0;
        req       = '0;
        rel_valid = 1'b0;
        step();
        step();
        step();
        chk("rand_grant_count", gcnt, 1000);
`ifndef ESM_SCHED_DETERMINISTIC_EN
        for (int s = 0; s < 16; s++) begin
            chk($sformatf("rand_slot%0d_share", s), (slot_cnt[s] >= 38 && slot_cnt[s] <= 86), 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
